shift_reg_sequencer: RTL and testbench
======================================

Name: shift_reg_sequencer

Overview:
- Command-driven controller that sequences a WIDTH-bit multi-mode shift register.
- Accepts one command (data, shift mode, shift count) over a valid/ready handshake.
- Drives the register's sel/d_in through a load phase and then N shift cycles.
- Captures the register output and returns it with a one-cycle result_valid pulse. Sits between a host/datapath FSM and the shift register instance.

Parameters:
- WIDTH, 4, width of shift register data.
- CNT_W, 4, width of shift count field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept command.
- cmd_data  input  WIDTH  value parallel-loaded into register.
- cmd_mode  input  3  000 SRL, 001 SLL, 010 ROR, 011 ROL, 100 ASR; 101-111 illegal.
- cmd_count  input  CNT_W  number of shift cycles (0 allowed).
- cmd_abort  input  1  cancel in-flight command.
- sr_sel  output  3  to register: 000 hold, 001 load, 010 SRL, 011 SLL, 100 ROR, 101 ROL, 110 ASR, 111 clear.
- sr_d_in  output  WIDTH  to register parallel input.
- sr_q  input  WIDTH  register output.
- busy  output  1  high in any state except IDLE.
- result  output  WIDTH  captured register value.
- result_valid  output  1  one-cycle pulse, result updated.
- mode_err  output  1  one-cycle pulse, illegal mode accepted.
- aborted  output  1  one-cycle pulse, command cancelled.

Behaviour:
- One clock, clk. reset is synchronous and active-high: at a rising edge with reset=1, state←IDLE, counter←0, result←0, result_valid/mode_err/aborted←0.
- sr_sel, sr_d_in, cmd_ready and busy are Moore outputs decoded from state; no combinational input-to-output paths.
- In IDLE: sr_sel=000, sr_d_in=0, cmd_ready=1.
- States: IDLE, LOAD, SHIFT, CAPTURE, ABORT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at an edge: latch data, mode and count; go to LOAD.
  - Illegal mode: the command is still accepted, the latched count is forced to 0, and mode_err pulses in the cycle after acceptance.
- LOAD:
  - sr_sel=001, sr_d_in=latched data.
  - Next state is SHIFT with counter=count if count≠0, otherwise CAPTURE.
- SHIFT:
  - sr_sel = mode code (SRL→010, SLL→011, ROR→100, ROL→101, ASR→110). counter decrements each edge.
  - When counter==1 at an edge, go to CAPTURE.
  - Exactly count shift cycles occur. Counts ≥ WIDTH are not clamped: SRL/SLL go to zero, rotates wrap, ASR fills with the sign bit.
- CAPTURE:
  - sr_sel=000.
  - At the edge: result←sr_q, result_valid←1 for one cycle, go to IDLE.
- Latency: with acceptance edge E0, the register loads at E1, the last shift happens at E(count+1), and result is captured at E(count+2). result_valid is high during the cycle after E(count+2), coincident with IDLE/cmd_ready=1. Back-to-back commands are therefore possible.
- cmd_valid while busy: ignored (cmd_ready=0); no command queuing.
- cmd_abort:
  - Sampled only in LOAD or SHIFT. It takes priority over the normal transition: go to ABORT.
  - ABORT drives sr_sel=111 (clear) for one cycle, then returns to IDLE. aborted pulses in the cycle after ABORT; result is unchanged and result_valid is not asserted.
  - cmd_abort in IDLE or CAPTURE has no effect.
- reset mid-operation overrides abort and all transitions: the next cycle is IDLE with sr_sel=000, no result_valid, no aborted.
- The controller never resets the shift register itself; register contents after a mid-operation reset are don't-care.

Test Plan:
- Bench setup: WIDTH=4, with a behavioural register model decoding the sr_sel codes above.
- SLL: data 0101, mode 001, count 1 → sr_sel sequence 001,011,000. result=1010, result_valid high exactly 3 edges after acceptance.
- ROR with wrap: data 1011, mode 010, count 5 → five cycles of sr_sel=100, result=1101, result_valid 7 edges after acceptance. The check passes only if busy=1 and cmd_ready=0 throughout.
- Zero count / illegal mode:
  - data 1001, count 0 → sr_sel 001 then 000, result=1001 at edge +2.
  - Repeat with mode 111, count 9 → mode_err pulse, result=1001, no shift sel ever driven.
- ASR: data 1000, mode 100, count 2 → result=1110. Then issue a second command in the result_valid cycle: it must be accepted and complete correctly.
- Abort: data 1111, SRL, count 6, cmd_abort during the 3rd SHIFT cycle → sr_sel=111 for one cycle, aborted pulse, no result_valid, result keeps its previous value, cmd_ready=1 afterwards.
- Reset: assert reset during SHIFT with cmd_valid held high → next cycle IDLE, all pulses 0, result=0. Deasserting reset with cmd_valid=1 accepts a new command on the following edge.

Source files
------------

// File: rtl/shift_reg_sequencer.sv
// Command-driven sequencer for a multi-mode shift register: accepts one
// command, loads the register, issues N shift cycles and returns the result.
module shift_reg_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [2:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_abort,
  output logic [2:0]       sr_sel,
  output logic [WIDTH-1:0] sr_d_in,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             mode_err,
  output logic             aborted
);

  localparam logic [2:0] SEL_HOLD  = 3'b000;
  localparam logic [2:0] SEL_LOAD  = 3'b001;
  localparam logic [2:0] SEL_SRL   = 3'b010;
  localparam logic [2:0] SEL_SLL   = 3'b011;
  localparam logic [2:0] SEL_ROR   = 3'b100;
  localparam logic [2:0] SEL_ROL   = 3'b101;
  localparam logic [2:0] SEL_ASR   = 3'b110;
  localparam logic [2:0] SEL_CLEAR = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_ABORT
  } state_t;

  state_t           r_state;
  logic [2:0]       r_shift_sel;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_counter;
  logic [2:0]       r_sr_sel;
  logic [WIDTH-1:0] r_sr_d_in;
  logic             r_cmd_ready;
  logic             r_busy;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;
  logic             r_mode_err;
  logic             r_aborted;

  logic [2:0]       w_shift_sel;
  logic             w_mode_legal;

  // Translate the command's shift mode into the register's select code
  always_comb begin
    w_shift_sel = SEL_HOLD;
    case (cmd_mode)
      3'b000:  w_shift_sel = SEL_SRL;
      3'b001:  w_shift_sel = SEL_SLL;
      3'b010:  w_shift_sel = SEL_ROR;
      3'b011:  w_shift_sel = SEL_ROL;
      3'b100:  w_shift_sel = SEL_ASR;
      default: w_shift_sel = SEL_HOLD;
    endcase
  end

  assign w_mode_legal = (cmd_mode <= 3'b100);

  // Sequencer state machine; Moore outputs are registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_shift_sel    <= SEL_HOLD;
      r_count        <= '0;
      r_counter      <= '0;
      r_sr_sel       <= SEL_HOLD;
      r_sr_d_in      <= '0;
      r_cmd_ready    <= 1'b1;
      r_busy         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_mode_err     <= 1'b0;
      r_aborted      <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_mode_err     <= 1'b0;
      r_aborted      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_shift_sel <= w_shift_sel;
            // An illegal mode still runs, but as a load-and-capture only
            r_count     <= w_mode_legal ? cmd_count : '0;
            r_mode_err  <= ~w_mode_legal;
            r_state     <= S_LOAD;
            r_sr_sel    <= SEL_LOAD;
            r_sr_d_in   <= cmd_data;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          r_sr_d_in <= '0;
          if (cmd_abort) begin
            r_state   <= S_ABORT;
            r_sr_sel  <= SEL_CLEAR;
            r_counter <= '0;
          end else if (r_count != '0) begin
            r_state   <= S_SHIFT;
            r_sr_sel  <= r_shift_sel;
            r_counter <= r_count;
          end else begin
            r_state  <= S_CAPTURE;
            r_sr_sel <= SEL_HOLD;
          end
        end
        S_SHIFT: begin
          if (cmd_abort) begin
            r_state   <= S_ABORT;
            r_sr_sel  <= SEL_CLEAR;
            r_counter <= '0;
          end else begin
            r_counter <= r_counter - CNT_W'(1);
            if (r_counter == CNT_W'(1)) begin
              r_state  <= S_CAPTURE;
              r_sr_sel <= SEL_HOLD;
            end
          end
        end
        S_CAPTURE: begin
          r_result       <= sr_q;
          r_result_valid <= 1'b1;
          r_state        <= S_IDLE;
          r_sr_sel       <= SEL_HOLD;
          r_cmd_ready    <= 1'b1;
          r_busy         <= 1'b0;
        end
        S_ABORT: begin
          r_aborted   <= 1'b1;
          r_state     <= S_IDLE;
          r_sr_sel    <= SEL_HOLD;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_sr_sel    <= SEL_HOLD;
          r_sr_d_in   <= '0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign sr_sel       = r_sr_sel;
  assign sr_d_in      = r_sr_d_in;
  assign busy         = r_busy;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign mode_err     = r_mode_err;
  assign aborted      = r_aborted;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: behavioural 4-bit register model, a table of
// directed commands, and hand-written abort / reset sequences.
module tb_shift_reg_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_data;
  logic [2:0] cmd_mode;
  logic [3:0] cmd_count;
  logic       cmd_abort;
  logic [2:0] sr_sel;
  logic [3:0] sr_d_in;
  logic [3:0] sr_q = 4'b0000;
  logic       busy;
  logic [3:0] result;
  logic       result_valid;
  logic       mode_err;
  logic       aborted;

  int errors = 0;
  int checks = 0;

  shift_reg_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_mode(cmd_mode), .cmd_count(cmd_count),
    .cmd_abort(cmd_abort), .sr_sel(sr_sel), .sr_d_in(sr_d_in), .sr_q(sr_q),
    .busy(busy), .result(result), .result_valid(result_valid),
    .mode_err(mode_err), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Behavioural multi-mode shift register driven by the sequencer
  always_ff @(posedge clk) begin
    case (sr_sel)
      3'b001:  sr_q <= sr_d_in;
      3'b010:  sr_q <= {1'b0, sr_q[3:1]};
      3'b011:  sr_q <= {sr_q[2:0], 1'b0};
      3'b100:  sr_q <= {sr_q[0], sr_q[3:1]};
      3'b101:  sr_q <= {sr_q[2:0], sr_q[3]};
      3'b110:  sr_q <= {sr_q[3], sr_q[3:1]};
      3'b111:  sr_q <= 4'b0000;
      default: sr_q <= sr_q;
    endcase
  end

  typedef struct {
    logic [3:0] data;
    logic [2:0] mode;
    logic [3:0] count;
    logic [3:0] exp_res;
    logic       exp_merr;
    int         exp_lat;
    bit         b2b;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] sel_for(input logic [2:0] m);
    case (m)
      3'b000:  return 3'b010;
      3'b001:  return 3'b011;
      3'b010:  return 3'b100;
      3'b011:  return 3'b101;
      3'b100:  return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int         lat;
    int         bad;
    int         ce;
    logic       merr0;
    logic [2:0] exp_sel;
    lat   = -1;
    bad   = 0;
    merr0 = 1'b0;
    ce    = v.exp_lat - 2;
    if (!v.b2b) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = v.data;
    cmd_mode  = v.mode;
    cmd_count = v.count;
    chk($sformatf("v%0d_ready_pre", idx), 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (k == 0) exp_sel = 3'b001;
      else if (k <= ce) exp_sel = sel_for(v.mode);
      else exp_sel = 3'b000;
      if (sr_sel !== exp_sel) bad++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) bad++;
      if (k == 0) begin
        merr0 = mode_err;
        if (sr_d_in !== v.data) bad++;
      end else if (mode_err !== 1'b0) bad++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_result", idx), 32'(result), 32'(v.exp_res));
    chk($sformatf("v%0d_mode_err", idx), 32'(merr0), 32'(v.exp_merr));
    chk($sformatf("v%0d_seq_violations", idx), 32'(bad), 32'd0);
    chk($sformatf("v%0d_idle_after", idx), 32'({busy, cmd_ready}), 32'b01);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{4'b0101, 3'b001, 4'd1,  4'b1010, 1'b0, 3,  1'b0};
    vecs[1]  = '{4'b1011, 3'b010, 4'd5,  4'b1101, 1'b0, 7,  1'b0};
    vecs[2]  = '{4'b1001, 3'b000, 4'd0,  4'b1001, 1'b0, 2,  1'b0};
    vecs[3]  = '{4'b1001, 3'b111, 4'd9,  4'b1001, 1'b1, 2,  1'b0};
    vecs[4]  = '{4'b1000, 3'b100, 4'd2,  4'b1110, 1'b0, 4,  1'b0};
    vecs[5]  = '{4'b0110, 3'b011, 4'd3,  4'b0011, 1'b0, 5,  1'b1};
    vecs[6]  = '{4'b1101, 3'b000, 4'd4,  4'b0000, 1'b0, 6,  1'b0};
    vecs[7]  = '{4'b0001, 3'b001, 4'd15, 4'b0000, 1'b0, 17, 1'b0};
    vecs[8]  = '{4'b0111, 3'b100, 4'd6,  4'b0000, 1'b0, 8,  1'b0};
    vecs[9]  = '{4'b1010, 3'b101, 4'd3,  4'b1010, 1'b1, 2,  1'b0};
    vecs[10] = '{4'b1011, 3'b011, 4'd4,  4'b1011, 1'b0, 6,  1'b0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_abort = 1'b0;
    cmd_data = 4'd0; cmd_mode = 3'd0; cmd_count = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 32'({cmd_ready, busy, sr_sel, sr_d_in}), 32'b1_0_000_0000);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_pulses", 32'({result_valid, mode_err, aborted}), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // cmd_abort during CAPTURE and the following IDLE cycle is ignored
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 4'b0011; cmd_mode = 3'b001; cmd_count = 4'd1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("capab_capture_state", 32'({sr_sel, busy}), 32'b000_1);
    cmd_abort = 1'b1;
    @(negedge clk);
    chk("capab_result_valid", 32'({result_valid, aborted}), 32'b10);
    chk("capab_result", 32'(result), 32'b0110);
    @(negedge clk);
    chk("capab_idle_abort", 32'({aborted, busy, result_valid}), 32'd0);
    cmd_abort = 1'b0;

    // Abort in the third SHIFT cycle of SRL x6
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 4'b1111; cmd_mode = 3'b000; cmd_count = 4'd6;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_shift3_sel", 32'(sr_sel), 32'b010);
    cmd_abort = 1'b1;
    @(negedge clk);
    chk("abort_clear_sel", 32'({sr_sel, busy, cmd_ready, result_valid}), 32'b111_1_0_0);
    cmd_abort = 1'b0;
    @(negedge clk);
    chk("abort_pulse", 32'({aborted, result_valid}), 32'b10);
    chk("abort_result_kept", 32'(result), 32'b0110);
    chk("abort_idle", 32'({cmd_ready, busy, sr_sel}), 32'b1_0_000);
    chk("abort_reg_cleared", 32'(sr_q), 32'd0);
    @(negedge clk);
    chk("abort_pulse_width", 32'({aborted, result_valid}), 32'b00);

    // Reset in SHIFT with cmd_valid and cmd_abort held, then restart
    cmd_valid = 1'b1; cmd_data = 4'b0101; cmd_mode = 3'b000; cmd_count = 4'd8;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst2_in_shift", 32'({sr_sel, busy}), 32'b010_1);
    reset = 1'b1; cmd_abort = 1'b1; cmd_valid = 1'b1;
    cmd_data = 4'b0011; cmd_mode = 3'b001; cmd_count = 4'd1;
    @(negedge clk);
    chk("rst2_idle", 32'({cmd_ready, busy, sr_sel}), 32'b1_0_000);
    chk("rst2_pulses", 32'({result_valid, mode_err, aborted}), 32'd0);
    chk("rst2_result", 32'(result), 32'd0);
    reset = 1'b0; cmd_abort = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst2_accept", 32'({sr_sel, sr_d_in, busy}), 32'b001_0011_1);
    lat = -1;
    for (int k = 1; k < 12; k++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("rst2_latency", 32'(lat), 32'd3);
    chk("rst2_result_after", 32'(result), 32'b0110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
